// File: rtl/ps2_kbd_rx_if.sv
// ps2_kbd_rx_if: CPU-side read handshake and status between ps2_kbd_rx and its consumer
interface ps2_kbd_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_rd;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  err_frame;
    logic                  overflow;

    modport master (input in_rd, output in_data, in_valid, err_frame, overflow);
    modport slave  (output in_rd, input in_data, in_valid, err_frame, overflow);
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard frame receiver with scan-code FIFO; KBD_BREAK_FILTER_EN drops 0xF0 and the byte after it
module ps2_kbd_rx #(
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev;
    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_ok;
    logic [TW-1:0] tcnt;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          err_q, ovf_q;

    logic fall, bit_in, stop_edge, good, push_req, pop, full, push_ok, valid;
    assign fall      = clk_prev & ~clk_sync[1];
    assign bit_in    = dat_sync[1];
    assign stop_edge = fall && state == STOP;
    assign good      = stop_edge && bit_in && parity_ok;
    assign valid     = cnt != '0;
    assign full      = cnt == (AW+1)'(FIFO_DEPTH);
    assign pop       = bus.in_rd && valid;
    assign push_ok   = push_req && (!full || pop);

`ifdef KBD_BREAK_FILTER_EN
    logic brk_pending;
    assign push_req = good && !brk_pending && shreg != 8'hF0;

    // A break prefix arms the filter; the next good byte is swallowed and disarms it
    always_ff @(posedge clk) begin
        if (!rst_n) brk_pending <= 1'b0;
        else if (good) brk_pending <= !brk_pending && shreg == 8'hF0;
    end
`else
    assign push_req = good;
`endif

    // Two-flop synchronisers plus the previous synchronised clock for falling-edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    // Frame FSM: sample on each PS/2 falling edge; abandon a stalled frame after the timeout
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            parity_ok <= 1'b0;
            tcnt      <= '0;
        end else if (fall) begin
            tcnt <= '0;
            case (state)
                IDLE: if (!bit_in) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                end
                DATA: begin
                    shreg   <= {bit_in, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= PARITY;
                end
                PARITY: begin
                    parity_ok <= ^{shreg, bit_in};
                    state     <= STOP;
                end
                default: state <= IDLE;
            endcase
        end else if (state != IDLE) begin
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state <= IDLE;
                tcnt  <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // Error pulse, sticky overflow, and FIFO pointer/occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
        end else begin
            err_q <= stop_edge && !(bit_in && parity_ok);
            if (push_req && full && !pop) ovf_q <= 1'b1;
            if (push_ok) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            if (push_ok && !pop) cnt <= cnt + 1'b1;
            else if (pop && !push_ok) cnt <= cnt - 1'b1;
        end
    end

    // Storage array carries no reset; its contents are hidden while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= shreg;
    end

    assign bus.in_valid  = valid;
    assign bus.in_data   = valid ? DATA_WIDTH'(mem[rp]) : '0;
    assign bus.err_frame = err_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed table-driven bench for ps2_kbd_rx, plus overflow, timeout, full-with-pop and break sequences
module tb_ps2_kbd_rx;
    localparam int DW   = 16;
    localparam int TO   = 200;
    localparam int HALF = 10;

    typedef struct {
        logic [7:0]  code;
        logic        flip;
        logic        stop;
        logic        exp_valid;
        logic [15:0] exp_data;
        int          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   err_cnt = 0;
    logic saw_valid = 1'b0;
    vec_t vt[8];

    ps2_kbd_rx_if #(.DATA_WIDTH(DW)) bus ();

    ps2_kbd_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus.master)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.err_frame) err_cnt++;
        if (bus.in_valid) saw_valid = 1'b1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input logic rd);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        if (rd) begin
            cyc(2);
            bus.in_rd = 1'b1;
            cyc(1);
            bus.in_rd = 1'b0;
            cyc(HALF - 3);
        end else begin
            cyc(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic flip, input logic stop, input logic rd, input int nbits);
        logic [10:0] f;
        f = {stop, ~^b ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], rd && i == 10);
        cyc(HALF);
    endtask

    task automatic pop_one();
        bus.in_rd = 1'b1;
        cyc(1);
        bus.in_rd = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        int e0;
        logic [7:0] fill [4];
        logic [15:0] exp4 [4];
        fill = '{8'h15, 8'h1D, 8'h24, 8'h2D};
        vt[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 16'h001C, 0};
        vt[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 16'h0000, 1};
        vt[2] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'h0000, 1};
        vt[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 16'h0000, 0};
        vt[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 16'h00FF, 0};
        vt[5] = '{8'h5A, 1'b0, 1'b1, 1'b1, 16'h005A, 0};
        vt[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 16'h0000, 1};
        vt[7] = '{8'hE0, 1'b0, 1'b1, 1'b1, 16'h00E0, 0};
        bus.in_rd = 1'b0;
        do_reset();
        chk("rst_valid", 32'(bus.in_valid), 0);
        chk("rst_data", 32'(bus.in_data), 0);
        chk("rst_err", 32'(bus.err_frame), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);

        for (int i = 0; i < 8; i++) begin
            e0 = err_cnt;
            send(vt[i].code, vt[i].flip, vt[i].stop, 1'b0, 11);
            chk($sformatf("vec%0d_valid", i), 32'(bus.in_valid), 32'(vt[i].exp_valid));
            chk($sformatf("vec%0d_data", i), 32'(bus.in_data), 32'(vt[i].exp_data));
            chk($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vt[i].exp_err));
            if (vt[i].exp_valid) begin
                pop_one();
                chk($sformatf("vec%0d_pop_valid", i), 32'(bus.in_valid), 0);
                chk($sformatf("vec%0d_pop_data", i), 32'(bus.in_data), 0);
            end
        end

        pop_one();
        chk("rd_empty_valid", 32'(bus.in_valid), 0);

        for (int i = 0; i < 4; i++) send(fill[i], 1'b0, 1'b1, 1'b0, 11);
        chk("fill_ovf", 32'(bus.overflow), 0);
        send(8'h2C, 1'b0, 1'b1, 1'b0, 11);
        chk("ovf_set", 32'(bus.overflow), 1);
        exp4 = '{16'h0015, 16'h001D, 16'h0024, 16'h002D};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ovf_pop%0d_valid", i), 32'(bus.in_valid), 1);
            chk($sformatf("ovf_pop%0d_data", i), 32'(bus.in_data), 32'(exp4[i]));
            pop_one();
        end
        chk("ovf_drain_valid", 32'(bus.in_valid), 0);
        chk("ovf_sticky", 32'(bus.overflow), 1);

        e0 = err_cnt;
        send(8'h00, 1'b0, 1'b1, 1'b0, 4);
        cyc(TO + 10);
        chk("to_idle_valid", 32'(bus.in_valid), 0);
        send(8'h32, 1'b0, 1'b1, 1'b0, 11);
        chk("to_valid", 32'(bus.in_valid), 1);
        chk("to_data", 32'(bus.in_data), 32'h0032);
        chk("to_err", 32'(err_cnt - e0), 0);
        pop_one();
        chk("to_drain_valid", 32'(bus.in_valid), 0);

        do_reset();
        chk("rst2_ovf", 32'(bus.overflow), 0);
        for (int i = 0; i < 4; i++) send(fill[i], 1'b0, 1'b1, 1'b0, 11);
        send(8'h2C, 1'b0, 1'b1, 1'b1, 11);
        chk("fullpop_ovf", 32'(bus.overflow), 0);
        exp4 = '{16'h001D, 16'h0024, 16'h002D, 16'h002C};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fullpop%0d_valid", i), 32'(bus.in_valid), 1);
            chk($sformatf("fullpop%0d_data", i), 32'(bus.in_data), 32'(exp4[i]));
            pop_one();
        end
        chk("fullpop_drain_valid", 32'(bus.in_valid), 0);

        saw_valid = 1'b0;
        send(8'hF0, 1'b0, 1'b1, 1'b0, 11);
        send(8'h1C, 1'b0, 1'b1, 1'b0, 11);
`ifdef KBD_BREAK_FILTER_EN
        chk("brk_never_valid", 32'(saw_valid), 0);
        send(8'h1C, 1'b0, 1'b1, 1'b0, 11);
        chk("brk_after_data", 32'(bus.in_data), 32'h001C);
        pop_one();
`else
        chk("brk_f0_data", 32'(bus.in_data), 32'h00F0);
        pop_one();
        chk("brk_1c_data", 32'(bus.in_data), 32'h001C);
        pop_one();
`endif
        chk("brk_drain_valid", 32'(bus.in_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- PS/2 keyboard receiver sitting directly upstream of the CPU's IN instruction path.
- Deserialises frames from the board `kbd` pins and buffers scan codes in a small FIFO.
- Presents buffered codes, zero-extended to the CPU data width, with a valid/read-strobe handshake.
- Instantiated inside `top` between the `kbd` pins and the CPU's input port.

Parameters:
- DATA_WIDTH, 16, width of `in_data`. Must be >= 8; scan code occupies bits [7:0], upper bits 0.
- FIFO_DEPTH, 4, scan-code entries. Power of two, >= 2.
- TIMEOUT_CYCLES, 50000, `clk` cycles allowed between PS/2 falling edges mid-frame before the frame is abandoned.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, synchronous, active-low.
- ps2_clk  input  1  raw PS/2 clock from pin, asynchronous.
- ps2_data  input  1  raw PS/2 data from pin, asynchronous.
- in_rd  input  1  one-cycle CPU read strobe; pops FIFO head.
- in_data  output  DATA_WIDTH  FIFO head, zero-extended; 0 when empty.
- in_valid  output  1  FIFO not empty.
- err_frame  output  1  one-cycle pulse on parity or stop-bit error.
- overflow  output  1  sticky; set when a byte is dropped because FIFO is full.

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous and active-low on `rst_n`.
- Reset values: all state is cleared when `rst_n`=0 at a clk edge.
  - FIFO empty; `in_valid`=0, `in_data`=0, `err_frame`=0, `overflow`=0.
  - FSM goes to IDLE.
  - Synchroniser flops are set to 1.
  - A frame in progress at reset is discarded.
- Input synchronisation: `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - A falling edge is registered prev=1, cur=0 on the synchronised clock.
  - Data is sampled only on that edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on falling edge with data=0, go to DATA, bit count=0. Falling edge with data=1 is ignored (stay IDLE).
  - DATA: shift data in LSB first. After the 8th bit, go to PARITY.
  - PARITY: capture the parity bit; parity_ok = XOR(8 data bits, parity bit) == 1 (odd parity). Go to STOP.
  - STOP: on falling edge, if data=1 and parity_ok, push byte; otherwise drop the byte and pulse `err_frame` for 1 cycle. Return to IDLE in both cases.
- Timeout:
  - In any state other than IDLE, a counter clears on each falling edge and increments otherwise.
  - At TIMEOUT_CYCLES-1, go to IDLE and discard the partial frame silently (no `err_frame`).
  - Counter is held at 0 in IDLE.
- FIFO push:
  - Occurs in the cycle the stop edge is detected.
  - `in_valid`/`in_data` update on the following clk edge (1-cycle latency from edge detect; 3 cycles from the pin).
- FIFO pop: `in_rd`=1 with `in_valid`=1 pops; the next entry appears the next cycle. `in_rd` while empty is ignored.
- Full FIFO:
  - Push without a same-cycle pop: new byte dropped, `overflow` set (sticky until reset).
  - Push with a same-cycle pop: both are accepted, count unchanged, no overflow.
- Empty FIFO with simultaneous push and `in_rd`: `in_rd` is ignored; byte is stored; `in_valid`=1 next cycle.
- Pointer arithmetic: read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: KBD_BREAK_FILTER_EN.
- Defined:
  - A received 0xF0 is not pushed; it sets `brk_pending`.
  - The next valid byte is discarded and clears `brk_pending`.
  - 0xE0 and all other bytes are pushed normally.
  - A parity/stop error while `brk_pending` is set leaves `brk_pending` set.
  - Reset clears `brk_pending`.
- Undefined: every valid byte, including 0xF0, is pushed; no `brk_pending` logic is synthesised.

Test Plan:
- Reset for 2 cycles, then send a valid frame for 0x1C -> `in_valid`=1, `in_data`=16'h001C. Pulse `in_rd` -> `in_valid`=0, `in_data`=0 next cycle.
- Send 0x1C with parity bit flipped -> `err_frame` pulses exactly once, `in_valid` stays 0.
- Send 0x15, 0x1D, 0x24, 0x2D, 0x2C with no reads (FIFO_DEPTH=4) -> `overflow`=1. Four pops return 0x15, 0x1D, 0x24, 0x2D; `in_valid`=0 after the last pop.
- Send start bit plus 3 data bits, idle TIMEOUT_CYCLES+10 cycles, then a full frame for 0x32 -> only 0x32 appears, no `err_frame`.
- With FIFO full, assert `in_rd` in the same cycle as the stop-bit edge -> count stays 4, `overflow` stays 0, new byte lands at the tail.
- Send 0xF0 then 0x1C -> with KBD_BREAK_FILTER_EN defined, `in_valid` never rises; without it, pops return 0x00F0 then 0x001C.
